// File: rtl/r5p_degu_trace_commit.sv
// r5p_degu_trace_commit: merges fetch, write-back and LSU activity into one record per retired instruction, buffered in a FIFO.
module r5p_degu_trace_commit #(
  parameter  int XLEN  = 32,
  parameter  int GNUM  = 32,
  parameter  int DEPTH = 4,
  parameter  int CNTW  = 32,
  localparam int GLOG  = $clog2(GNUM)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifu_trn,
  input  logic [XLEN-1:0] ifu_adr,
  input  logic [XLEN-1:0] ifu_rdt,
  input  logic            gpr_wen,
  input  logic [GLOG-1:0] gpr_wid,
  input  logic [XLEN-1:0] gpr_wdt,
  input  logic            lsu_trn,
  input  logic            lsu_wen,
  input  logic [XLEN-1:0] lsu_adr,
  input  logic [XLEN-1:0] lsu_wdt,
  input  logic [XLEN-1:0] lsu_rdt,
  input  logic            flush,
  output logic            rec_vld,
  input  logic            rec_rdy,
  output logic [XLEN-1:0] rec_pc,
  output logic [XLEN-1:0] rec_ins,
  output logic            rec_csz,
  output logic            rec_gen,
  output logic [GLOG-1:0] rec_gid,
  output logic [XLEN-1:0] rec_gdt,
  output logic            rec_len,
  output logic            rec_lwe,
  output logic [XLEN-1:0] rec_lad,
  output logic [XLEN-1:0] rec_ldt,
  output logic [CNTW-1:0] cnt_ret,
  output logic [CNTW-1:0] cnt_drp,
  output logic            err_lsu
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
    logic            csz;
    logic            gen;
    logic [GLOG-1:0] gid;
    logic [XLEN-1:0] gdt;
    logic            len;
    logic            lwe;
    logic [XLEN-1:0] lad;
    logic [XLEN-1:0] ldt;
  } rec_t;
  logic            ifu_d, lsu_d, wen_d, acc_vld;
  logic [XLEN-1:0] iad_d, lad_d, wdt_d;
  rec_t            acc, mrg, nxt, head;
  rec_t            mem [DEPTH];
  logic [AW:0]     wp, rp;
  logic            push, pop, full, empty, ok;
  always_comb begin
    mrg = acc;
    if (lsu_d & acc_vld & ~acc.len) begin
      mrg.len = 1'b1;
      mrg.lwe = wen_d;
      mrg.lad = lad_d;
      mrg.ldt = wen_d ? wdt_d : lsu_rdt;
    end
    nxt     = '0;
    nxt.pc  = iad_d;
    nxt.csz = ifu_rdt[1:0] != 2'b11;
    nxt.ins = nxt.csz ? {{(XLEN-16){1'b0}}, ifu_rdt[15:0]} : ifu_rdt;
    nxt.gen = gpr_wen & |gpr_wid;
    nxt.gid = gpr_wid;
    nxt.gdt = gpr_wdt;
  end
  // a push in the same cycle as a pop always fits, even when full
  assign push  = acc_vld & (ifu_d | flush);
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = ~empty & rec_rdy;
  assign ok    = push & (~full | pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifu_d   <= 1'b0;
      lsu_d   <= 1'b0;
      wen_d   <= 1'b0;
      iad_d   <= '0;
      lad_d   <= '0;
      wdt_d   <= '0;
      acc     <= '0;
      acc_vld <= 1'b0;
      mem     <= '{default: '0};
      wp      <= '0;
      rp      <= '0;
      cnt_ret <= '0;
      cnt_drp <= '0;
      err_lsu <= 1'b0;
    end else begin
      ifu_d <= ifu_trn;
      iad_d <= ifu_adr;
      lsu_d <= lsu_trn;
      wen_d <= lsu_wen;
      lad_d <= lsu_adr;
      wdt_d <= lsu_wdt;
      if (ifu_d) begin
        acc     <= nxt;
        acc_vld <= 1'b1;
      end else if (flush) acc_vld <= 1'b0;
      else acc <= mrg;
      if (lsu_d & acc_vld & acc.len) err_lsu <= 1'b1;
      if (ok) begin
        mem[wp[AW-1:0]] <= mrg;
        wp              <= wp + 1'b1;
        cnt_ret         <= &cnt_ret ? cnt_ret : cnt_ret + 1'b1;
      end
      if (push & ~ok) cnt_drp <= &cnt_drp ? cnt_drp : cnt_drp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  assign head    = mem[rp[AW-1:0]];
  assign rec_vld = ~empty;
  assign rec_pc  = head.pc;
  assign rec_ins = head.ins;
  assign rec_csz = head.csz;
  assign rec_gen = head.gen;
  assign rec_gid = head.gid;
  assign rec_gdt = head.gdt;
  assign rec_len = head.len;
  assign rec_lwe = head.lwe;
  assign rec_lad = head.lad;
  assign rec_ldt = head.ldt;
endmodule

// File: tb/tb_r5p_degu_trace_commit.sv
// tb_r5p_degu_trace_commit: directed and randomized checks of the commit-record collector against a record-queue model.
module tb_r5p_degu_trace_commit;
  localparam int DEPTH = 4;
  logic        clk = 0, rst_n = 0;
  logic        ifu_trn = 0, gpr_wen = 0, lsu_trn = 0, lsu_wen = 0, flush = 0, rec_rdy = 1;
  logic [31:0] ifu_adr = 0, ifu_rdt = 0, gpr_wdt = 0, lsu_adr = 0, lsu_wdt = 0, lsu_rdt = 0;
  logic [4:0]  gpr_wid = 0;
  logic        rec_vld, rec_csz, rec_gen, rec_len, rec_lwe, err_lsu;
  logic [31:0] rec_pc, rec_ins, rec_gdt, rec_lad, rec_ldt, cnt_ret, cnt_drp;
  logic [4:0]  rec_gid;
  int errors = 0, checks = 0;

  r5p_degu_trace_commit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ifu_trn(ifu_trn), .ifu_adr(ifu_adr), .ifu_rdt(ifu_rdt),
    .gpr_wen(gpr_wen), .gpr_wid(gpr_wid), .gpr_wdt(gpr_wdt), .lsu_trn(lsu_trn),
    .lsu_wen(lsu_wen), .lsu_adr(lsu_adr), .lsu_wdt(lsu_wdt), .lsu_rdt(lsu_rdt),
    .flush(flush), .rec_vld(rec_vld), .rec_rdy(rec_rdy), .rec_pc(rec_pc), .rec_ins(rec_ins),
    .rec_csz(rec_csz), .rec_gen(rec_gen), .rec_gid(rec_gid), .rec_gdt(rec_gdt),
    .rec_len(rec_len), .rec_lwe(rec_lwe), .rec_lad(rec_lad), .rec_ldt(rec_ldt),
    .cnt_ret(cnt_ret), .cnt_drp(cnt_drp), .err_lsu(err_lsu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, ins;
    logic        csz, gen;
    logic [4:0]  gid;
    logic [31:0] gdt;
    logic        len, lwe;
    logic [31:0] lad, ldt;
  } rec_t;

  // Model: the instruction in flight, what the core saw last cycle, and the queue of retired records.
  rec_t        fq[$];
  rec_t        pend;
  bit          pend_vld, f_vld, l_vld, l_we, m_err;
  logic [31:0] f_adr, l_adr, l_wdt;
  int          m_ret, m_drp;
  bit          s_f, s_l, s_wen;
  logic [31:0] s_rdt, s_wdt, s_lrdt;
  logic [4:0]  s_wid;

  task automatic model_reset;
    fq.delete();
    pend_vld = 0; f_vld = 0; l_vld = 0; m_err = 0; m_ret = 0; m_drp = 0; s_f = 0; s_l = 0;
    ifu_trn = 0; lsu_trn = 0; flush = 0; gpr_wen = 0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic fetch(input logic [31:0] adr, rdt, input logic wen, input logic [4:0] wid, input logic [31:0] wdt);
    ifu_trn = 1; ifu_adr = adr;
    s_f = 1; s_rdt = rdt; s_wen = wen; s_wid = wid; s_wdt = wdt;
  endtask

  task automatic lsu(input logic we, input logic [31:0] adr, wdt, rdt);
    lsu_trn = 1; lsu_wen = we; lsu_adr = adr; lsu_wdt = wdt;
    s_l = 1; s_lrdt = rdt;
  endtask

  task automatic tick;
    rec_t o;
    bit   push;
    @(posedge clk);
    o = pend;
    if (l_vld && pend_vld) begin
      if (o.len) m_err = 1;
      else begin
        o.len = 1; o.lwe = l_we; o.lad = l_adr; o.ldt = l_we ? l_wdt : lsu_rdt;
      end
    end
    push = pend_vld && (f_vld || flush);
    if (fq.size() != 0 && rec_rdy) void'(fq.pop_front());
    if (push) begin
      if (fq.size() < DEPTH) begin fq.push_back(o); m_ret++; end
      else m_drp++;
    end
    if (f_vld) begin
      pend.pc  = f_adr;
      pend.csz = ifu_rdt[1:0] != 2'b11;
      pend.ins = pend.csz ? (ifu_rdt & 32'h0000ffff) : ifu_rdt;
      pend.gen = gpr_wen && gpr_wid != 0;
      pend.gid = gpr_wid; pend.gdt = gpr_wdt;
      pend.len = 0; pend.lwe = 0; pend.lad = 0; pend.ldt = 0;
      pend_vld = 1;
    end else if (flush) pend_vld = 0;
    else pend = o;
    f_vld = ifu_trn; f_adr = ifu_adr;
    l_vld = lsu_trn; l_we = lsu_wen; l_adr = lsu_adr; l_wdt = lsu_wdt;
    #1;
    ifu_trn = 0; lsu_trn = 0; flush = 0; gpr_wen = 0;
    if (s_f) begin ifu_rdt = s_rdt; gpr_wen = s_wen; gpr_wid = s_wid; gpr_wdt = s_wdt; end
    if (s_l) lsu_rdt = s_lrdt;
    s_f = 0; s_l = 0;
  endtask

  task automatic test_reset;
    checks++;
    if ({rec_vld, rec_pc, rec_ins, rec_len, cnt_ret, cnt_drp, err_lsu} !== '0) begin
      errors++;
      $display("FAIL reset_state: got vld=%b pc=%h ret=%0d drp=%0d err=%b, want all zero", rec_vld, rec_pc, cnt_ret, cnt_drp, err_lsu);
    end
  endtask

  task automatic test_basic;
    fetch(32'h80000000, 32'h00500093, 1, 5'd1, 32'h5); tick();
    fetch(32'h80000004, 32'hffff4501, 0, 5'd0, 32'h0); tick();
    checks++;
    if (rec_vld !== 1'b0) begin errors++; $display("FAIL first_fr_no_push: got vld=%b want 0", rec_vld); end
    tick();
    checks++;
    if ({rec_vld, rec_pc, rec_ins, rec_csz, rec_gen, rec_gid, rec_gdt, rec_len} !== {1'b1, 32'h80000000, 32'h00500093, 1'b0, 1'b1, 5'd1, 32'h5, 1'b0}) begin
      errors++;
      $display("FAIL basic_rec1: got vld=%b pc=%h ins=%h csz=%b gen=%b gid=%0d gdt=%h len=%b", rec_vld, rec_pc, rec_ins, rec_csz, rec_gen, rec_gid, rec_gdt, rec_len);
    end
    flush = 1; tick();
    checks++;
    if ({rec_vld, rec_pc, rec_ins, rec_csz, rec_gen, rec_len, cnt_ret} !== {1'b1, 32'h80000004, 32'h00004501, 1'b1, 1'b0, 1'b0, 32'd2}) begin
      errors++;
      $display("FAIL basic_rec2_flush: got vld=%b pc=%h ins=%h csz=%b gen=%b len=%b ret=%0d, want pc=80000004 ins=00004501 csz=1 ret=2", rec_vld, rec_pc, rec_ins, rec_csz, rec_gen, rec_len, cnt_ret);
    end
    tick();
  endtask

  task automatic test_store;
    fetch(32'h80000010, 32'h00112023, 0, 5'd0, 32'h0); tick();
    lsu(1, 32'h1000, 32'hdeadbeef, 32'h0); tick();
    fetch(32'h80000014, 32'h00000013, 0, 5'd0, 32'h0); tick();
    tick();
    checks++;
    if ({rec_vld, rec_pc, rec_len, rec_lwe, rec_lad, rec_ldt} !== {1'b1, 32'h80000010, 1'b1, 1'b1, 32'h1000, 32'hdeadbeef}) begin
      errors++;
      $display("FAIL store_attach: got vld=%b pc=%h len=%b lwe=%b lad=%h ldt=%h, want pc=80000010 store 1000/deadbeef", rec_vld, rec_pc, rec_len, rec_lwe, rec_lad, rec_ldt);
    end
    flush = 1; tick();
    tick();
  endtask

  task automatic test_load_coincide;
    fetch(32'h80000020, 32'h00002283, 0, 5'd0, 32'h0); tick();
    tick();
    lsu(0, 32'h2000, 32'h0, 32'h12345678);
    fetch(32'h80000024, 32'h00000013, 0, 5'd0, 32'h0); tick();
    tick();
    checks++;
    if ({rec_vld, rec_pc, rec_len, rec_lwe, rec_lad, rec_ldt} !== {1'b1, 32'h80000020, 1'b1, 1'b0, 32'h2000, 32'h12345678}) begin
      errors++;
      $display("FAIL load_on_fr: got vld=%b pc=%h len=%b lwe=%b lad=%h ldt=%h, want pc=80000020 load 2000/12345678", rec_vld, rec_pc, rec_len, rec_lwe, rec_lad, rec_ldt);
    end
    flush = 1; tick();
    checks++;
    if ({rec_vld, rec_pc, rec_len} !== {1'b1, 32'h80000024, 1'b0}) begin
      errors++;
      $display("FAIL load_next_clean: got vld=%b pc=%h len=%b, want pc=80000024 len=0", rec_vld, rec_pc, rec_len);
    end
    tick();
  endtask

  task automatic test_x0;
    fetch(32'h80000030, 32'h00700013, 1, 5'd0, 32'h7); tick();
    tick();
    flush = 1; tick();
    checks++;
    if ({rec_vld, rec_pc, rec_gen} !== {1'b1, 32'h80000030, 1'b0}) begin
      errors++;
      $display("FAIL x0_write: got vld=%b pc=%h gen=%b, want pc=80000030 gen=0", rec_vld, rec_pc, rec_gen);
    end
    tick();
  endtask

  task automatic test_full;
    logic [31:0] want [4] = '{32'h80000108, 32'h8000010c, 32'h80000200, 32'h0};
    do_reset();
    rec_rdy = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      fetch(32'h80000100 + 32'(4 * i), 32'h00000013, 0, 5'd0, 32'h0); tick();
      tick();
    end
    flush = 1; tick();
    checks++;
    if ({rec_vld, rec_pc, cnt_ret, cnt_drp} !== {1'b1, 32'h80000100, 32'(DEPTH), 32'd2}) begin
      errors++;
      $display("FAIL full_drop: got vld=%b pc=%h ret=%0d drp=%0d, want pc=80000100 ret=%0d drp=2", rec_vld, rec_pc, cnt_ret, cnt_drp, DEPTH);
    end
    fetch(32'h80000200, 32'h00000013, 0, 5'd0, 32'h0); tick();
    tick();
    rec_rdy = 1; flush = 1; tick();
    checks++;
    if ({rec_vld, rec_pc, cnt_ret, cnt_drp} !== {1'b1, 32'h80000104, 32'(DEPTH + 1), 32'd2}) begin
      errors++;
      $display("FAIL full_push_pop: got vld=%b pc=%h ret=%0d drp=%0d, want pc=80000104 ret=%0d drp=2", rec_vld, rec_pc, cnt_ret, cnt_drp, DEPTH + 1);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({rec_vld, rec_vld ? rec_pc : 32'h0} !== {k < 3, want[k]}) begin
        errors++;
        $display("FAIL full_drain%0d: got vld=%b pc=%h, want vld=%b pc=%h", k, rec_vld, rec_pc, k < 3, want[k]);
      end
    end
  endtask

  task automatic test_err;
    do_reset();
    fetch(32'h80000300, 32'h00000013, 0, 5'd0, 32'h0); tick();
    lsu(1, 32'h10, 32'h11, 32'h0); tick();
    lsu(0, 32'h20, 32'h0, 32'h99); tick();
    checks++;
    if (err_lsu !== 1'b0) begin errors++; $display("FAIL err_early: got err=%b want 0", err_lsu); end
    tick();
    checks++;
    if (err_lsu !== 1'b1) begin errors++; $display("FAIL err_second_lsu: got err=%b want 1", err_lsu); end
    flush = 1; tick();
    checks++;
    if ({rec_vld, rec_len, rec_lwe, rec_lad, rec_ldt, err_lsu} !== {1'b1, 1'b1, 1'b1, 32'h10, 32'h11, 1'b1}) begin
      errors++;
      $display("FAIL err_keep_first: got vld=%b len=%b lwe=%b lad=%h ldt=%h err=%b, want store 10/11 err=1", rec_vld, rec_len, rec_lwe, rec_lad, rec_ldt, err_lsu);
    end
    tick();
  endtask

  task automatic test_random;
    logic [168:0] act, exp;
    rec_t e;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rec_rdy = $urandom_range(0, 99) < 55;
      if ($urandom_range(0, 99) < 45)
        fetch($urandom & 32'hfffffffe, $urandom_range(0, 1) ? ($urandom | 32'h3) : $urandom,
              1'($urandom), 5'($urandom), $urandom);
      if ($urandom_range(0, 99) < 30) lsu(1'($urandom), $urandom, $urandom, $urandom);
      flush = $urandom_range(0, 99) < 12;
      tick();
      checks++;
      if (rec_vld !== (fq.size() != 0)) begin
        errors++;
        $display("FAIL rnd_vld@%0d: got %b want %b", n, rec_vld, fq.size() != 0);
      end
      if (fq.size() != 0) begin
        e = fq[0];
        exp = {e.pc, e.ins, e.csz, e.gen, e.len, e.gen ? {e.gid, e.gdt} : 37'h0, e.len ? {e.lwe, e.lad, e.ldt} : 65'h0};
        act = {rec_pc, rec_ins, rec_csz, rec_gen, rec_len, e.gen ? {rec_gid, rec_gdt} : 37'h0, e.len ? {rec_lwe, rec_lad, rec_ldt} : 65'h0};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL rnd_rec@%0d: got %h want %h", n, act, exp);
        end
      end
      checks++;
      if ({cnt_ret, cnt_drp, err_lsu} !== {32'(m_ret), 32'(m_drp), m_err}) begin
        errors++;
        $display("FAIL rnd_cnt@%0d: got ret=%0d drp=%0d err=%b want ret=%0d drp=%0d err=%b", n, cnt_ret, cnt_drp, err_lsu, m_ret, m_drp, m_err);
      end
    end
  endtask

  task automatic test_async_reset;
    rec_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      fetch(32'h80000400 + 32'(4 * i), 32'h00000013, 1, 5'd3, 32'h1); tick();
      tick();
    end
    checks++;
    if (rec_vld !== 1'b1) begin errors++; $display("FAIL areset_pre: got vld=%b want 1", rec_vld); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({rec_vld, cnt_ret, cnt_drp, err_lsu, rec_pc} !== '0) begin
      errors++;
      $display("FAIL areset_now: got vld=%b ret=%0d drp=%0d err=%b pc=%h, want all zero", rec_vld, cnt_ret, cnt_drp, err_lsu, rec_pc);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    rec_rdy = 1; flush = 1; tick();
    checks++;
    if ({rec_vld, cnt_ret} !== '0) begin
      errors++;
      $display("FAIL areset_discard: got vld=%b ret=%0d, want 0 0", rec_vld, cnt_ret);
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1;
    test_basic();
    test_store();
    test_load_coincide();
    test_x0();
    test_full();
    test_err();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
